// File: rtl/tpu_ctrl_if.sv
// Command and array/SRAM control bundle for the systolic-array sequencer.
// The master side issues jobs; the slave side is the controller itself.
interface tpu_ctrl_if #(
  parameter int ARRAY_SIZE = 5,
  parameter int VEC_W      = 8,
  parameter int ADDR_W     = 8
);
  logic                  start;
  logic [VEC_W-1:0]      vec_cnt;
  logic                  skip_wload;
  logic                  busy;
  logic                  done;
  logic                  w_rd_en;
  logic [ADDR_W-1:0]     w_addr;
  logic [ARRAY_SIZE-1:0] weight_en;
  logic                  in_rd_en;
  logic [ADDR_W-1:0]     in_addr;
  logic                  go;
  logic [ARRAY_SIZE-1:0] out_valid;

  modport master (
    output start, vec_cnt, skip_wload,
    input  busy, done, w_rd_en, w_addr, weight_en, in_rd_en, in_addr, go, out_valid
  );

  modport slave (
    input  start, vec_cnt, skip_wload,
    output busy, done, w_rd_en, w_addr, weight_en, in_rd_en, in_addr, go, out_valid
  );
endinterface

// File: rtl/tpu_ctrl.sv
// Job sequencer for an N x N weight-stationary systolic array: weight load,
// input streaming, array-wide go and per-column output-valid generation.
module tpu_ctrl #(
  parameter int ARRAY_SIZE = 5,
  parameter int VEC_W      = 8,
  parameter int ADDR_W     = 8
) (
  input  logic     clk,
  input  logic     rst,
  tpu_ctrl_if.slave bus
);
  localparam int N     = ARRAY_SIZE;
  localparam int LOG_N = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = ((VEC_W > LOG_N) ? VEC_W : LOG_N) + 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_W    = 3'd1,
    LOAD_WAIT = 3'd2,
    COMPUTE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [VEC_W-1:0]   k_r, k_s;
  logic [CNT_W-1:0]   k_ext_r, k_ext_s;

  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               w_rd_en_r, w_rd_en_s;
  logic [ADDR_W-1:0]  w_addr_r, w_addr_s;
  logic [N-1:0]       weight_en_r, weight_en_s;
  logic               in_rd_en_r, in_rd_en_s;
  logic [ADDR_W-1:0]  in_addr_r, in_addr_s;
  logic               go_r, go_s;
  logic [N-1:0]       out_valid_r, out_valid_s;

  assign k_ext_r = {{(CNT_W-VEC_W){1'b0}}, k_r};
  assign k_ext_s = {{(CNT_W-VEC_W){1'b0}}, k_s};

  // Next-state, cycle counter and latched vector count.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    k_s     = k_r;
    case (state_r)
      IDLE: begin
        if (bus.start && (bus.vec_cnt != {VEC_W{1'b0}})) begin
          k_s     = bus.vec_cnt;
          cnt_s   = {CNT_W{1'b0}};
          state_s = bus.skip_wload ? COMPUTE : LOAD_W;
        end else begin
          cnt_s = {CNT_W{1'b0}};
        end
      end
      LOAD_W: begin
        if (cnt_r == CNT_W'(N - 1)) begin
          state_s = LOAD_WAIT;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      LOAD_WAIT: begin
        state_s = COMPUTE;
        cnt_s   = {CNT_W{1'b0}};
      end
      COMPUTE: begin
        // go spans K + 2N cycles: K issue cycles plus the skewed drain.
        if (cnt_r == k_ext_r + CNT_W'(2 * N - 1)) begin
          state_s = DONE;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output values for the upcoming cycle, decoded from next state so they can be registered.
  always_comb begin
    busy_s      = (state_s != IDLE);
    done_s      = 1'b0;
    w_rd_en_s   = 1'b0;
    w_addr_s    = {ADDR_W{1'b0}};
    weight_en_s = {N{1'b0}};
    in_rd_en_s  = 1'b0;
    in_addr_s   = {ADDR_W{1'b0}};
    go_s        = 1'b0;
    out_valid_s = {N{1'b0}};
    case (state_s)
      LOAD_W: begin
        w_rd_en_s = 1'b1;
        w_addr_s  = ADDR_W'(cnt_s);
        // Row r is written when its SRAM data returns, one cycle after address r.
        for (int r = 0; r < N; r++) begin
          weight_en_s[r] = (cnt_s == CNT_W'(r + 1));
        end
      end
      LOAD_WAIT: begin
        weight_en_s[N-1] = 1'b1;
      end
      COMPUTE: begin
        go_s = 1'b1;
        if (cnt_s < k_ext_s) begin
          in_rd_en_s = 1'b1;
          in_addr_s  = ADDR_W'(cnt_s);
        end else begin
          in_rd_en_s = 1'b0;
        end
        for (int j = 0; j < N; j++) begin
          out_valid_s[j] = (cnt_s >= CNT_W'(N + j + 1)) &&
                           (cnt_s <= k_ext_s + CNT_W'(N + j));
        end
      end
      DONE: begin
        done_s = 1'b1;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      k_r         <= {VEC_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      w_rd_en_r   <= 1'b0;
      w_addr_r    <= {ADDR_W{1'b0}};
      weight_en_r <= {N{1'b0}};
      in_rd_en_r  <= 1'b0;
      in_addr_r   <= {ADDR_W{1'b0}};
      go_r        <= 1'b0;
      out_valid_r <= {N{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      k_r         <= k_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      w_rd_en_r   <= w_rd_en_s;
      w_addr_r    <= w_addr_s;
      weight_en_r <= weight_en_s;
      in_rd_en_r  <= in_rd_en_s;
      in_addr_r   <= in_addr_s;
      go_r        <= go_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.w_rd_en   = w_rd_en_r;
  assign bus.w_addr    = w_addr_r;
  assign bus.weight_en = weight_en_r;
  assign bus.in_rd_en  = in_rd_en_r;
  assign bus.in_addr   = in_addr_r;
  assign bus.go        = go_r;
  assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_tpu_ctrl.sv
// Directed bench for tpu_ctrl: per-cycle timeline compare plus a table of
// hand-computed per-job totals (latency, go length, read counts, first valids).
module tb_tpu_ctrl;
  localparam int N      = 5;
  localparam int VEC_W  = 8;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tpu_ctrl_if #(.ARRAY_SIZE(N), .VEC_W(VEC_W), .ADDR_W(ADDR_W)) bus ();

  tpu_ctrl #(.ARRAY_SIZE(N), .VEC_W(VEC_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int k;
    bit skip;
    bit keep;
    int done_cyc;
    int go_cnt;
    int wrd_cnt;
    int inrd_cnt;
    int last_addr;
    int ov0_first;
    int ovl_first;
    int we_seen;
  } job_t;

  job_t jobs [4];

  int r_done, r_go, r_wrd, r_inrd, r_last, r_ov0, r_ovl, r_we;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({bus.busy, bus.done, bus.w_rd_en, bus.in_rd_en, bus.go,
                 bus.weight_en, bus.out_valid, bus.w_addr, bus.in_addr});
  endfunction

  // Run one job from the current cycle (S), comparing every cycle with the
  // timeline implied by K and skip; optionally assert rst during cycle abort_at.
  task automatic run_job(input int k, input bit skip, input bit keep, input int abort_at);
    int t_first, t_last;
    logic e_busy, e_done, e_wrd, e_inrd, e_go;
    logic [N-1:0] e_we, e_ov;
    logic [4:0] a_ctl, e_ctl;
    bit bad;
    t_first = skip ? 1 : N + 2;
    t_last  = t_first + k + 2 * N;
    r_done = 0; r_go = 0; r_wrd = 0; r_inrd = 0; r_last = -1;
    r_ov0 = 0; r_ovl = 0; r_we = 0;
    bus.start      = 1'b1;
    bus.vec_cnt    = VEC_W'(k);
    bus.skip_wload = skip;
    for (int t = 1; t <= t_last; t++) begin
      step();
      if (keep) begin
        bus.vec_cnt    = VEC_W'(9);
        bus.skip_wload = ~skip;
      end else begin
        bus.start = 1'b0;
      end
      e_busy = 1'b1;
      e_done = (t == t_last);
      e_wrd  = !skip && (t <= N);
      e_inrd = (t >= t_first) && (t < t_first + k);
      e_go   = (t >= t_first) && (t <= t_last - 1);
      e_we   = '0;
      if (!skip && t >= 2 && t <= N + 1) e_we[t-2] = 1'b1;
      for (int j = 0; j < N; j++)
        e_ov[j] = (t >= t_first + N + j + 1) && (t <= t_first + N + j + k);
      e_ctl = {e_busy, e_done, e_wrd, e_inrd, e_go};
      a_ctl = {bus.busy, bus.done, bus.w_rd_en, bus.in_rd_en, bus.go};
      bad = (a_ctl !== e_ctl) || (bus.weight_en !== e_we) || (bus.out_valid !== e_ov);
      if (e_wrd && bus.w_addr !== ADDR_W'(t - 1)) bad = 1'b1;
      if (e_inrd && bus.in_addr !== ADDR_W'(t - t_first)) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL cyc k=%0d t=%0d act ctl=%b we=%b ov=%b wa=%0d ia=%0d exp ctl=%b we=%b ov=%b wa=%0d ia=%0d",
                 k, t, a_ctl, bus.weight_en, bus.out_valid, bus.w_addr, bus.in_addr,
                 e_ctl, e_we, e_ov, e_wrd ? t - 1 : 0, e_inrd ? t - t_first : 0);
      end
      if (bus.go) r_go++;
      if (bus.w_rd_en) r_wrd++;
      if (bus.in_rd_en) begin r_inrd++; r_last = int'(bus.in_addr); end
      if (bus.done && r_done == 0) r_done = t;
      if (bus.out_valid[0] && r_ov0 == 0) r_ov0 = t;
      if (bus.out_valid[N-1] && r_ovl == 0) r_ovl = t;
      r_we = r_we | int'(bus.weight_en);
      if (t == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_outs_zero", all_outs(), 0);
        for (int i = 0; i < 3; i++) begin
          step();
          chk("abort_no_done", int'({bus.busy, bus.done}), 0);
        end
        return;
      end
    end
    step();
    chk("idle_after_done", int'({bus.busy, bus.done}), 0);
  endtask

  task automatic check_job(input job_t j);
    chk("done_cycle", r_done, j.done_cyc);
    chk("go_cycles", r_go, j.go_cnt);
    chk("w_rd_cycles", r_wrd, j.wrd_cnt);
    chk("in_rd_cycles", r_inrd, j.inrd_cnt);
    chk("last_in_addr", r_last, j.last_addr);
    chk("ov0_first", r_ov0, j.ov0_first);
    chk("ovlast_first", r_ovl, j.ovl_first);
    chk("weight_en_seen", r_we, j.we_seen);
  endtask

  initial begin
    job_t second;
    //          k    skip  keep  done  go   wrd inrd last ov0 ov4 we
    jobs[0] = '{3,   1'b0, 1'b0, 20,   13,  5,  3,   2,   13, 17, 31};
    jobs[1] = '{1,   1'b1, 1'b0, 12,   11,  0,  1,   0,   7,  11, 0};
    jobs[2] = '{255, 1'b0, 1'b0, 272,  265, 5,  255, 254, 13, 17, 31};
    jobs[3] = '{4,   1'b1, 1'b1, 15,   14,  0,  4,   3,   7,  11, 0};
    second  = '{2,   1'b1, 1'b0, 13,   12,  0,  2,   1,   7,  11, 0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.vec_cnt = '0;
    bus.skip_wload = 1'b0;
    step();
    step();
    chk("reset_outs_zero", all_outs(), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      run_job(jobs[i].k, jobs[i].skip, jobs[i].keep, 0);
      check_job(jobs[i]);
    end

    // Start still held from the previous job: accepted in the first idle cycle.
    run_job(second.k, second.skip, 1'b0, 0);
    check_job(second);

    // Reset in COMPUTE at T+4 (K=10 with load, T=7), then a normal job.
    run_job(10, 1'b0, 1'b0, 11);
    run_job(jobs[0].k, jobs[0].skip, 1'b0, 0);
    check_job(jobs[0]);

    // vec_cnt of zero never starts a job.
    bus.start = 1'b1;
    bus.vec_cnt = '0;
    bus.skip_wload = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("zero_k_idle", int'({bus.busy, bus.done, bus.go}), 0);
    end
    bus.start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
